apb_completer_regs: RTL and testbench

- APB completer (slave) that mates with the team's DEAD_CAFE read/increment/write APB master.
- Decodes a small word-aligned register window and inserts a programmable number of wait states.
- Flags errors on illegal accesses and keeps transfer statistics counters.
- Sits on the peripheral bus as the target of the master's SETUP/ACCESS sequence.

---
 rtl/apb_completer_regs.sv | 137 +++++++++++++
 tb/tb_apb_completer_regs.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/apb_completer_regs.sv
// APB completer with a 4-word register window, programmable wait states,
// error flagging on illegal accesses and transfer statistics counters.
module apb_completer_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CAF0,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        pclk_i,
  input  logic        prst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o,
  output logic [7:0]  err_cnt_o
);

  localparam int         DATA_W  = 32;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wcnt;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [DATA_W-1:0] reg3;
  logic              hit;
  logic [1:0]        idx;
  logic              err;
  logic              complete;
  logic [DATA_W-1:0] rd_val;
  logic              unused_addr_lsbs;

  // Byte-lane bits are not part of the word-aligned decode.
  assign unused_addr_lsbs = ^paddr_i[1:0];

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Address decode, error classification and read mux.
  always_comb begin
    hit    = (paddr_i[31:4] == BASE_ADDR[31:4]);
    idx    = paddr_i[3:2];
    err    = !hit || (pwrite_i && (idx == 2'd0));
    rd_val = '0;
    if (hit) begin
      case (idx)
        2'd0:    rd_val = ID_VALUE;
        2'd1:    rd_val = reg1;
        2'd2:    rd_val = reg2;
        default: rd_val = reg3;
      endcase
    end
  end

  assign pready_o = (state == ST_READY);
  assign complete = (state == ST_READY) && psel_i && penable_i;

  // Next-state logic: setup -> optional wait cycles -> one ready cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (psel_i && !penable_i)
          state_nxt = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
      end
      ST_WAIT: begin
        if (!psel_i)
          state_nxt = ST_IDLE;
        else if (wcnt == 4'd1)
          state_nxt = ST_READY;
      end
      ST_READY: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register and wait-state counter.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && psel_i && !penable_i)
        wcnt <= WAIT_LD;
      else if (state == ST_WAIT && psel_i)
        wcnt <= wcnt - 4'd1;
    end
  end

  // Read capture on entry to ST_READY, register writes and counters on completion.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      prdata_o  <= '0;
      pslverr_o <= 1'b0;
      reg1      <= '0;
      reg2      <= '0;
      reg3      <= '0;
      rd_cnt_o  <= '0;
      wr_cnt_o  <= '0;
      err_cnt_o <= '0;
    end else begin
      if (state_nxt == ST_READY) begin
        prdata_o  <= rd_val;
        pslverr_o <= err;
      end else begin
        prdata_o  <= '0;
        pslverr_o <= 1'b0;
      end
      if (complete) begin
        if (err) begin
          err_cnt_o <= sat_inc8(err_cnt_o);
        end else if (pwrite_i) begin
          wr_cnt_o <= wr_cnt_o + 16'd1;
          case (idx)
            2'd1:    reg1 <= pwdata_i;
            2'd2:    reg2 <= pwdata_i;
            2'd3:    reg3 <= pwdata_i;
            default: ;
          endcase
        end else begin
          rd_cnt_o <= rd_cnt_o + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Directed bench for apb_completer_regs: three instances with 1, 0 and 3 wait states.
module tb_apb_completer_regs;

  logic        pclk;
  logic        prst;
  logic [2:0]  psel_v;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [15:0] rd_cnt  [3];
  logic [15:0] wr_cnt  [3];
  logic [7:0]  err_cnt [3];

  int total = 0;
  int bad   = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  apb_completer_regs #(.WAIT_CYCLES(1)) u_w1 (
    .pclk_i(pclk), .prst_i(prst), .psel_i(psel_v[0]), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]),
    .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0]), .err_cnt_o(err_cnt[0]));

  apb_completer_regs #(.WAIT_CYCLES(0)) u_w0 (
    .pclk_i(pclk), .prst_i(prst), .psel_i(psel_v[1]), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]),
    .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1]), .err_cnt_o(err_cnt[1]));

  apb_completer_regs #(.WAIT_CYCLES(3)) u_w3 (
    .pclk_i(pclk), .prst_i(prst), .psel_i(psel_v[2]), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]),
    .rd_cnt_o(rd_cnt[2]), .wr_cnt_o(wr_cnt[2]), .err_cnt_o(err_cnt[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transfer on instance k; entered and left #1 after a rising edge so
  // consecutive calls are back-to-back.
  task automatic xfer(input int k, input logic [31:0] a, input logic w,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic er, output int waits);
    bit done;
    psel_v    = 3'b000;
    psel_v[k] = 1'b1;
    penable   = 1'b0;
    paddr     = a;
    pwrite    = w;
    pwdata    = d;
    rd        = 'x;
    er        = 1'bx;
    waits     = 0;
    done      = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge pclk);
      if (pready[k] === 1'b1) begin
        rd   = prdata[k];
        er   = pslverr[k];
        done = 1'b1;
      end else begin
        waits++;
        @(posedge pclk); #1;
      end
    end
    chk("xfer_completed", {31'd0, done}, 32'd1);
    @(posedge pclk); #1;
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          wt;

    prst = 1'b1; psel_v = 3'b000; penable = 1'b0;
    paddr = '0; pwrite = 1'b0; pwdata = '0;
    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;
    @(negedge pclk);
    chk("rst_pready", {31'd0, pready[0]}, 32'd0);
    chk("rst_prdata", prdata[0], 32'd0);
    chk("rst_pslverr", {31'd0, pslverr[0]}, 32'd0);
    chk("rst_rd_cnt", {16'd0, rd_cnt[0]}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt[0]}, 32'd0);
    @(posedge pclk); #1;

    // First read of reg3 after reset, one wait state.
    xfer(0, 32'hDEAD_CAFE, 1'b0, 32'd0, rd, er, wt);
    chk("rd0_waits", wt, 32'd1);
    chk("rd0_data", rd, 32'd0);
    chk("rd0_err", {31'd0, er}, 32'd0);
    chk("rd0_cnt", {16'd0, rd_cnt[0]}, 32'd1);

    // Master read/increment/write loop, back-to-back.
    xfer(0, 32'hDEAD_CAFE, 1'b0, 32'd0, rd, er, wt);
    chk("loop_rd_a", rd, 32'd0);
    xfer(0, 32'hDEAD_CAFE, 1'b1, rd + 32'd1, rd, er, wt);
    chk("loop_wr_a_err", {31'd0, er}, 32'd0);
    xfer(0, 32'hDEAD_CAFE, 1'b0, 32'd0, rd, er, wt);
    chk("loop_rd_b", rd, 32'd1);
    xfer(0, 32'hDEAD_CAFE, 1'b1, rd + 32'd1, rd, er, wt);
    chk("loop_rd_cnt", {16'd0, rd_cnt[0]}, 32'd3);
    chk("loop_wr_cnt", {16'd0, wr_cnt[0]}, 32'd2);
    xfer(0, 32'hDEAD_CAFC, 1'b0, 32'd0, rd, er, wt);
    chk("loop_reg3", rd, 32'd2);
    xfer(0, 32'hDEAD_CAF8, 1'b0, 32'd0, rd, er, wt);
    chk("reg2_untouched", rd, 32'd0);

    // Illegal write to the ID register, ID read, miss read.
    xfer(0, 32'hDEAD_CAF0, 1'b1, 32'hFFFF_FFFF, rd, er, wt);
    chk("idwr_err", {31'd0, er}, 32'd1);
    xfer(0, 32'hDEAD_CAF0, 1'b0, 32'd0, rd, er, wt);
    chk("idrd_data", rd, 32'hA5B0_0001);
    chk("idrd_err", {31'd0, er}, 32'd0);
    xfer(0, 32'h0000_1000, 1'b0, 32'd0, rd, er, wt);
    chk("miss_err", {31'd0, er}, 32'd1);
    chk("miss_data", rd, 32'd0);
    chk("err_cnt2", {24'd0, err_cnt[0]}, 32'd2);
    chk("err_rd_cnt", {16'd0, rd_cnt[0]}, 32'd6);
    chk("err_wr_cnt", {16'd0, wr_cnt[0]}, 32'd2);

    // Zero wait states.
    xfer(1, 32'hDEAD_CAF4, 1'b1, 32'h1234_5678, rd, er, wt);
    chk("w0_wr_waits", wt, 32'd0);
    chk("w0_wr_err", {31'd0, er}, 32'd0);
    xfer(1, 32'hDEAD_CAF4, 1'b0, 32'd0, rd, er, wt);
    chk("w0_rd_waits", wt, 32'd0);
    chk("w0_rd_data", rd, 32'h1234_5678);

    // Error counter saturation.
    for (int i = 0; i < 255; i++) xfer(1, 32'h0000_1000, 1'b0, 32'd0, rd, er, wt);
    chk("err_cnt_ff", {24'd0, err_cnt[1]}, 32'h0000_00FF);
    xfer(1, 32'h0000_1000, 1'b0, 32'd0, rd, er, wt);
    chk("err_cnt_sat", {24'd0, err_cnt[1]}, 32'h0000_00FF);
    chk("w0_rd_cnt", {16'd0, rd_cnt[1]}, 32'd1);

    // Master abort during the second wait cycle of a write (three wait states).
    psel_v = 3'b100; penable = 1'b0; paddr = 32'hDEAD_CAF8; pwrite = 1'b1; pwdata = 32'hCAFE_0002;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel_v = 3'b000; penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready", {31'd0, pready[2]}, 32'd0);
    @(posedge pclk); #1;
    chk("abort_wr_cnt", {16'd0, wr_cnt[2]}, 32'd0);
    chk("abort_err_cnt", {24'd0, err_cnt[2]}, 32'd0);
    xfer(2, 32'hDEAD_CAF8, 1'b0, 32'd0, rd, er, wt);
    chk("abort_rd_waits", wt, 32'd3);
    chk("abort_reg2", rd, 32'd0);
    chk("abort_rd_cnt", {16'd0, rd_cnt[2]}, 32'd1);
    xfer(2, 32'hDEAD_CAF8, 1'b1, 32'h0BAD_F00D, rd, er, wt);
    chk("w3_wr_waits", wt, 32'd3);
    xfer(2, 32'hDEAD_CAF8, 1'b0, 32'd0, rd, er, wt);
    chk("w3_reg2", rd, 32'h0BAD_F00D);

    // Reset asserted while a write sits in ST_WAIT.
    xfer(0, 32'hDEAD_CAF4, 1'b1, 32'h7777_7777, rd, er, wt);
    psel_v = 3'b001; penable = 1'b0; paddr = 32'hDEAD_CAF8; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF;
    @(posedge pclk); #1 penable = 1'b1; prst = 1'b1;
    @(posedge pclk); #1 prst = 1'b0; psel_v = 3'b000; penable = 1'b0;
    @(negedge pclk);
    chk("mrst_pready", {31'd0, pready[0]}, 32'd0);
    chk("mrst_rd_cnt", {16'd0, rd_cnt[0]}, 32'd0);
    chk("mrst_wr_cnt", {16'd0, wr_cnt[0]}, 32'd0);
    chk("mrst_err_cnt", {24'd0, err_cnt[0]}, 32'd0);
    @(posedge pclk); #1;
    xfer(0, 32'hDEAD_CAF4, 1'b0, 32'd0, rd, er, wt);
    chk("mrst_reg1", rd, 32'd0);
    xfer(0, 32'hDEAD_CAF8, 1'b0, 32'd0, rd, er, wt);
    chk("mrst_reg2", rd, 32'd0);
    xfer(0, 32'hDEAD_CAFC, 1'b0, 32'd0, rd, er, wt);
    chk("mrst_reg3", rd, 32'd0);
    chk("mrst_rd_cnt_after", {16'd0, rd_cnt[0]}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
